// File: rtl/tick_rate_ctrl.sv
// Run/pause/clear sequencer for the shared prescale counter; emits a one-cycle
// tick enable at 1 Hz/10 Hz/100 Hz/1 kHz plus a square wave and a tick tally.
module tick_rate_ctrl #(
  parameter int CLK_HZ = 100000000,
  parameter int CNT_W  = 27
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_pause,
  input  logic              clear,
  input  logic [1:0]        rate_sel,
  output logic              tick,
  output logic              clk_out,
  output logic [15:0]       tick_cnt,
  output logic              running,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TERM_1HZ   = CNT_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] TERM_10HZ  = CNT_W'(CLK_HZ / 10 - 1);
  localparam logic [CNT_W-1:0] TERM_100HZ = CNT_W'(CLK_HZ / 100 - 1);
  localparam logic [CNT_W-1:0] TERM_1KHZ  = CNT_W'(CLK_HZ / 1000 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] term_of(input logic [1:0] sel);
    case (sel)
      2'd0:    return TERM_1HZ;
      2'd1:    return TERM_10HZ;
      2'd2:    return TERM_100HZ;
      2'd3:    return TERM_1KHZ;
      default: return TERM_1HZ;
    endcase
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic             running_r;
  logic [CNT_W-1:0] count_r;
  logic [1:0]       act_sel_r;
  logic             tick_r;
  logic             clk_out_r;
  logic [15:0]      tick_cnt_r;
  logic [CNT_W-1:0] term_s;
  logic             wrap_s;

  // Terminal count follows only the latched selection, so rate changes land on a wrap.
  always_comb begin
    term_s = term_of(act_sel_r);
    wrap_s = (count_r == term_s);
  end

  // Next-state logic; clear wins over start_pause.
  always_comb begin
    state_next_s = state_r;
    if (clear) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_next_s = start_pause ? ST_RUN   : ST_IDLE;
        ST_RUN:   state_next_s = start_pause ? ST_PAUSE : ST_RUN;
        ST_PAUSE: state_next_s = start_pause ? ST_RUN   : ST_PAUSE;
        default:  state_next_s = ST_IDLE;
      endcase
    end
  end

  // State register with a registered running flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      running_r <= (state_next_s == ST_RUN);
    end
  end

  // Prescale datapath; a pause edge suppresses any wrap due on that same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r    <= {CNT_W{1'b0}};
      act_sel_r  <= 2'd0;
      tick_r     <= 1'b0;
      clk_out_r  <= 1'b0;
      tick_cnt_r <= 16'd0;
    end else if (clear) begin
      count_r    <= {CNT_W{1'b0}};
      act_sel_r  <= 2'd0;
      tick_r     <= 1'b0;
      clk_out_r  <= 1'b0;
      tick_cnt_r <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          count_r    <= {CNT_W{1'b0}};
          act_sel_r  <= rate_sel;
          tick_r     <= 1'b0;
          clk_out_r  <= 1'b0;
          tick_cnt_r <= 16'd0;
        end
        ST_RUN: begin
          if (start_pause) begin
            tick_r <= 1'b0;
          end else if (wrap_s) begin
            count_r    <= {CNT_W{1'b0}};
            tick_r     <= 1'b1;
            clk_out_r  <= ~clk_out_r;
            tick_cnt_r <= tick_cnt_r + 16'd1;
            act_sel_r  <= rate_sel;
          end else begin
            count_r <= count_r + CNT_ONE;
            tick_r  <= 1'b0;
          end
        end
        ST_PAUSE: begin
          tick_r <= 1'b0;
        end
        default: begin
          count_r    <= {CNT_W{1'b0}};
          act_sel_r  <= 2'd0;
          tick_r     <= 1'b0;
          clk_out_r  <= 1'b0;
          tick_cnt_r <= 16'd0;
        end
      endcase
    end
  end

  assign tick     = tick_r;
  assign clk_out  = clk_out_r;
  assign tick_cnt = tick_cnt_r;
  assign running  = running_r;
  assign state    = state_r;

endmodule

// File: tb/tb_tick_rate_ctrl.sv
// Directed self-checking bench for tick_rate_ctrl at CLK_HZ = 1000 (terms 999/99/9/0).
module tb_tick_rate_ctrl;

  logic        clk;
  logic        reset;
  logic        start_pause;
  logic        clear;
  logic [1:0]  rate_sel;
  logic        tick;
  logic        clk_out;
  logic [15:0] tick_cnt;
  logic        running;
  logic [1:0]  state;

  int n_chk;
  int n_fail;

  tick_rate_ctrl #(.CLK_HZ(1000), .CNT_W(10)) dut (
    .clk(clk), .reset(reset), .start_pause(start_pause), .clear(clear),
    .rate_sel(rate_sel), .tick(tick), .clk_out(clk_out), .tick_cnt(tick_cnt),
    .running(running), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sp;
    start_pause = 1'b1;
    step();
    start_pause = 1'b0;
  endtask

  // Expects 9 quiet cycles then a tick carrying the given tally.
  task automatic expect_period(input string name, input int idx);
    int bad;
    bad = 0;
    repeat (9) begin
      step();
      if (tick !== 1'b0) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      $display("FAIL %s_gap%0d: %0d early tick cycles, required 0", name, idx, bad);
      n_fail++;
    end
    step();
    n_chk++;
    if (tick !== 1'b1 || clk_out !== idx[0] || tick_cnt !== 16'(idx)) begin
      $display("FAIL %s_tick%0d: tick=%b clk_out=%b tick_cnt=%0d, required 1 %b %0d",
               name, idx, tick, clk_out, tick_cnt, idx[0], idx);
      n_fail++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start_pause = 1'b0; clear = 1'b0; rate_sel = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({state, running, tick, clk_out, tick_cnt} !== 21'd0) begin
      $display("FAIL reset_hold: outputs=%h, required 0", {state, running, tick, clk_out, tick_cnt});
      n_fail++;
    end
    reset = 1'b0;
    step();
    n_chk++;
    if ({state, running, tick, clk_out, tick_cnt} !== 21'd0) begin
      $display("FAIL reset_release: outputs=%h, required 0", {state, running, tick, clk_out, tick_cnt});
      n_fail++;
    end
  endtask

  task automatic test_run;
    rate_sel = 2'd2;
    step();
    pulse_sp();
    n_chk++;
    if (state !== 2'd1 || running !== 1'b1) begin
      $display("FAIL run_start: state=%0d running=%b, required 1 1", state, running);
      n_fail++;
    end
    for (int t = 1; t <= 5; t++) expect_period("run", t);
  endtask

  task automatic test_pause;
    int bad;
    repeat (4) step();
    pulse_sp();
    n_chk++;
    if (state !== 2'd2 || running !== 1'b0 || tick !== 1'b0) begin
      $display("FAIL pause_enter: state=%0d running=%b tick=%b, required 2 0 0", state, running, tick);
      n_fail++;
    end
    bad = 0;
    repeat (20) begin
      step();
      if (tick !== 1'b0 || tick_cnt !== 16'd5) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      $display("FAIL pause_hold: %0d bad cycles, required 0", bad);
      n_fail++;
    end
    pulse_sp();
    n_chk++;
    if (state !== 2'd1 || tick !== 1'b0) begin
      $display("FAIL pause_resume: state=%0d tick=%b, required 1 0", state, tick);
      n_fail++;
    end
    bad = 0;
    repeat (5) begin
      step();
      if (tick !== 1'b0) bad++;
    end
    step();
    n_chk++;
    if (bad !== 0 || tick !== 1'b1 || tick_cnt !== 16'd6) begin
      $display("FAIL pause_next_tick: early=%0d tick=%b tick_cnt=%0d, required 0 1 6", bad, tick, tick_cnt);
      n_fail++;
    end
  endtask

  task automatic test_rate_change;
    int bad;
    repeat (3) step();
    rate_sel = 2'd1;
    bad = 0;
    repeat (6) begin
      step();
      if (tick !== 1'b0) bad++;
    end
    step();
    n_chk++;
    if (bad !== 0 || tick !== 1'b1 || tick_cnt !== 16'd7) begin
      $display("FAIL rate_old_period: early=%0d tick=%b tick_cnt=%0d, required 0 1 7", bad, tick, tick_cnt);
      n_fail++;
    end
    bad = 0;
    repeat (99) begin
      step();
      if (tick !== 1'b0) bad++;
    end
    step();
    n_chk++;
    if (bad !== 0 || tick !== 1'b1 || tick_cnt !== 16'd8 || clk_out !== 1'b0) begin
      $display("FAIL rate_new_period: early=%0d tick=%b tick_cnt=%0d clk_out=%b, required 0 1 8 0",
               bad, tick, tick_cnt, clk_out);
      n_fail++;
    end
  endtask

  task automatic test_clear;
    repeat (5) step();
    clear = 1'b1; start_pause = 1'b1;
    step();
    clear = 1'b0; start_pause = 1'b0;
    n_chk++;
    if ({state, running, tick, clk_out, tick_cnt} !== 21'd0) begin
      $display("FAIL clear_outputs: outputs=%h, required 0", {state, running, tick, clk_out, tick_cnt});
      n_fail++;
    end
    rate_sel = 2'd2;
    repeat (2) step();
    n_chk++;
    if (state !== 2'd0) begin
      $display("FAIL clear_stays_idle: state=%0d, required 0", state);
      n_fail++;
    end
    pulse_sp();
    expect_period("clear_restart", 1);
  endtask

  task automatic test_reset_mid_pause;
    repeat (3) step();
    pulse_sp();
    n_chk++;
    if (state !== 2'd2) begin
      $display("FAIL rst_pause_enter: state=%0d, required 2", state);
      n_fail++;
    end
    repeat (2) step();
    #2;
    reset = 1'b1;
    #1;
    n_chk++;
    if ({state, running, tick, clk_out, tick_cnt} !== 21'd0) begin
      $display("FAIL rst_async: outputs=%h, required 0", {state, running, tick, clk_out, tick_cnt});
      n_fail++;
    end
    #7;
    reset = 1'b0;
    step();
    n_chk++;
    if (state !== 2'd0 || tick_cnt !== 16'd0) begin
      $display("FAIL rst_release: state=%0d tick_cnt=%0d, required 0 0", state, tick_cnt);
      n_fail++;
    end
    pulse_sp();
    expect_period("rst_restart", 1);
  endtask

  task automatic test_fast_wrap;
    int bad;
    clear = 1'b1;
    step();
    clear = 1'b0;
    rate_sel = 2'd3;
    step();
    pulse_sp();
    bad = 0;
    repeat (65535) begin
      step();
      if (tick !== 1'b1) bad++;
    end
    n_chk++;
    if (bad !== 0 || tick_cnt !== 16'hFFFF) begin
      $display("FAIL fast_continuous: low_cycles=%0d tick_cnt=%0d, required 0 65535", bad, tick_cnt);
      n_fail++;
    end
    step();
    n_chk++;
    if (tick !== 1'b1 || tick_cnt !== 16'd0 || clk_out !== 1'b0 || state !== 2'd1) begin
      $display("FAIL fast_wrap: tick=%b tick_cnt=%0d clk_out=%b state=%0d, required 1 0 0 1",
               tick, tick_cnt, clk_out, state);
      n_fail++;
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_run();
    test_pause();
    test_rate_change();
    test_clear();
    test_reset_mid_pause();
    test_fast_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
